cfg_bitstream_serializer: RTL and testbench
===========================================

// Module: cfg_bitstream_serializer
// PURPOSE
//  Reads a stored configuration image word-by-word from a synchronous config memory.
//  Emits it as a serial bitstream, bit 0 of word 0 first (LSB-first per word).
//  The stream carries a valid/ready handshake and feeds the product-term AND-array
//  config chain, readback/verify logic, or a .bit dump monitor in simulation.
//  It is the producer end of the bitstream that product-term config loading consumes.
// PARAMETERS
//  TOTAL_BITS  15033  config bits in the image; must be >0 (elaboration error otherwise)
//  WORD_W      16     memory word width; must be >=4
//  NWORDS      ceil(TOTAL_BITS/WORD_W)  derived, localparam
//  ADDR_W      max(1,clog2(NWORDS))     derived, localparam
//  CNT_W       clog2(TOTAL_BITS+1)      derived, localparam
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       begin a transfer; sampled only in IDLE
//  abort      in   1       cancel transfer; highest priority
//  mem_rd     out  1       memory read strobe
//  mem_addr   out  ADDR_W  word address
//  mem_rdata  in   WORD_W  read data, valid exactly 1 cycle after mem_rd
//  bit_out    out  1       serial config bit
//  bit_valid  out  1       bit_out valid
//  bit_ready  in   1       consumer accepts bit when valid&ready
//  bit_last   out  1       qualifies final bit (index TOTAL_BITS-1)
//  bit_count  out  CNT_W   bits accepted so far in current transfer
//  busy       out  1       transfer in progress
//  done       out  1       1-cycle pulse after last bit accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift and prefetch buffers cleared.
//  States:
//   - IDLE -(start)-> FETCH
//   - FETCH: mem_rd=1, addr 0 -> LOAD
//   - LOAD: capture mem_rdata into shift reg -> SHIFT
//   - SHIFT -(last bit accepted)-> DONE
//   - DONE: done=1 -> IDLE
//  Latency: start sampled at cycle T; mem_rd at T+1; bit_valid=1 with bit 0 at T+3.
//  busy=1 from T+1 through the last-bit handshake cycle; done pulses the following cycle with busy=0.
//  Handshake: once bit_valid rises it stays high until accepted; bit_out and bit_last are stable
//  while valid & !ready. Shift advances only on valid&ready.
//  Prefetch: in the first SHIFT cycle of word k (k<NWORDS-1), issue mem_rd for k+1 and capture
//  into the prefetch buffer one cycle later. With bit_ready held high, the stream is gapless across
//  word boundaries. At most one outstanding read; mem_rd never repeats for the same address.
//  Partial last word: only TOTAL_BITS-(NWORDS-1)*WORD_W bits of the last word are sent; upper bits
//  are ignored. bit_last is asserted on bit TOTAL_BITS-1 only.
//  bit_count increments by 1 per accepted bit and saturates at TOTAL_BITS; it resets to 0 on start.
//  start while busy or in DONE: ignored.
//  abort (any state): next cycle IDLE; bit_valid, busy and mem_rd go to 0; no done pulse; an
//  in-flight mem_rdata is discarded. abort has priority over start in the same cycle.
//  Single word (NWORDS=1): no prefetch read is issued.
// STRUCTURE
//  cfg_pkg: state encoding (IDLE, FETCH, LOAD, SHIFT, DONE) and a clog2 helper function.
//  Sub-module cfg_shift_word: loadable WORD_W shift register with valid-bit count, load port,
//  shift-enable and empty/last-bit flags. Instantiated once; the prefetch buffer lives in the parent.
// TESTING
//  1. TOTAL_BITS=6, WORD_W=4, mem={4'b0011 @1, 4'b1100 @0}, ready=1, start at T
//     -> bits 0,0,1,1,1,1 at T+3..T+8.
//     -> bit_last at T+8; done at T+9; only 2 reads issued (addr 0, 1).
//  2. Same image, bit_ready toggled 1,0,0,1,...
//     -> each bit is held stable while unaccepted; sequence unchanged; bit_count ends at 6.
//  3. TOTAL_BITS=12, WORD_W=4, ready=1
//     -> 12 consecutive valid cycles with no bubble at word boundaries.
//  4. abort asserted on the 3rd accepted bit of test 1
//     -> IDLE next cycle, valid=0, no done pulse.
//     -> A subsequent start replays from bit 0 with bit_count=0.
//  5. start pulsed during SHIFT -> ignored, output identical to test 1.
//     rst_n dropped mid-SHIFT -> all outputs 0 immediately (asynchronous).
//  6. TOTAL_BITS=5, WORD_W=4 -> bit 4 (word1 bit0) carries bit_last; word1 bits 1-3 never emitted.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration bitstream serializer.
// Holds the controller state encoding and an elaboration-time log2 helper.
package cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cfg_shift_word.sv
// Loadable LSB-first shift register for one config word.
// Tracks how many valid bits remain so partial words end early.
module cfg_shift_word #(
  parameter int W    = 16,
  parameter int NB_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic [W-1:0]    load_data,
  input  logic [NB_W-1:0] load_nbits,
  input  logic            shift,
  output logic            q,
  output logic            empty,
  output logic            last
);

  logic [W-1:0]    data;
  logic [NB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= load_nbits;
    end else if (shift && cnt != '0) begin
      data <= data >> 1;
      cnt  <= cnt - NB_W'(1);
    end
  end

  assign q     = data[0];
  assign empty = (cnt == '0);
  assign last  = (cnt == NB_W'(1));

endmodule

// File: rtl/cfg_bitstream_serializer.sv
// Streams a stored config image out of a synchronous memory, LSB-first,
// with one-word prefetch so word boundaries cost no bubble.
module cfg_bitstream_serializer
  import cfg_pkg::*;
#(
  parameter int TOTAL_BITS = 15033,
  parameter int WORD_W     = 16,
  localparam int NWORDS    = (TOTAL_BITS + WORD_W - 1) / WORD_W,
  localparam int ADDR_W    = (clog2(NWORDS) > 1) ? clog2(NWORDS) : 1,
  localparam int CNT_W     = clog2(TOTAL_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic [CNT_W-1:0]  bit_count,
  output logic              busy,
  output logic              done
);

  if (TOTAL_BITS <= 0) begin : g_bad_total
    $error("TOTAL_BITS must be greater than 0");
  end
  if (WORD_W < 4) begin : g_bad_word
    $error("WORD_W must be at least 4");
  end

  localparam int NB_W    = clog2(WORD_W + 1);
  localparam int LAST_NB = TOTAL_BITS - (NWORDS - 1) * WORD_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TOTAL_BITS);

  state_t state, state_nx;

  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] nidx;
  logic              first;
  logic              rd_pend;
  logic [WORD_W-1:0] pf_buf;

  logic              sh_load;
  logic              sh_shift;
  logic [WORD_W-1:0] sh_data;
  logic [NB_W-1:0]   sh_nbits;
  logic              sh_q;
  logic              sh_empty;
  logic              sh_last;

  logic fire;
  logic final_bit;
  logic at_last_word;

  cfg_shift_word #(
    .W    (WORD_W),
    .NB_W (NB_W)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (abort),
    .load       (sh_load),
    .load_data  (sh_data),
    .load_nbits (sh_nbits),
    .shift      (sh_shift),
    .q          (sh_q),
    .empty      (sh_empty),
    .last       (sh_last)
  );

  assign nidx         = widx + ADDR_W'(1);
  assign at_last_word = (widx == LAST_IDX);
  assign final_bit    = at_last_word & sh_last;

  assign bit_valid = (state == S_SHIFT) & ~sh_empty;
  assign fire      = bit_valid & bit_ready;
  assign bit_out   = bit_valid & sh_q;
  assign bit_last  = bit_valid & final_bit;
  assign busy      = (state == S_FETCH) | (state == S_LOAD) |
                     (state == S_SHIFT);
  assign done      = (state == S_DONE);

  // Prefetch of word k+1 goes out on the first SHIFT cycle of word k.
  assign mem_rd   = (state == S_FETCH) |
                    ((state == S_SHIFT) & first & ~at_last_word);
  assign mem_addr = ((state == S_SHIFT) & first) ? nidx : '0;

  always_comb begin
    state_nx = state;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = rd_pend ? mem_rdata : pf_buf;
    sh_nbits = NB_W'(WORD_W);
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        sh_load  = 1'b1;
        sh_data  = mem_rdata;
        sh_nbits = (NWORDS == 1) ? NB_W'(LAST_NB) : NB_W'(WORD_W);
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (fire) begin
          if (final_bit) begin
            state_nx = S_DONE;
          end else if (sh_last) begin
            sh_load  = 1'b1;
            sh_nbits = (nidx == LAST_IDX) ? NB_W'(LAST_NB)
                                          : NB_W'(WORD_W);
          end else begin
            sh_shift = 1'b1;
          end
        end
      end
      S_DONE: state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      widx      <= '0;
      first     <= 1'b0;
      rd_pend   <= 1'b0;
      pf_buf    <= '0;
      bit_count <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= (state == S_SHIFT) & mem_rd & ~abort;
      if (abort || state == S_IDLE) widx <= '0;
      else if (sh_load && state == S_SHIFT) widx <= nidx;
      if (abort) first <= 1'b0;
      else if (sh_load) first <= 1'b1;
      else if (state == S_SHIFT) first <= 1'b0;
      if (abort) pf_buf <= '0;
      else if (rd_pend) pf_buf <= mem_rdata;
      if (state == S_IDLE && start && !abort) bit_count <= '0;
      else if (fire && !abort && bit_count != CNT_MAX)
        bit_count <= bit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_serializer.sv
// Bench for the config bitstream serializer: four image geometries,
// table vectors, hand-built reset/abort sequences and random transfers.
module tb_cfg_bitstream_serializer;

  localparam int NI = 4;
  localparam int TBS [NI] = '{6, 12, 5, 37};
  localparam int WS  [NI] = '{4, 4, 4, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start  [NI];
  logic       abort  [NI];
  logic       ready  [NI];
  logic       mem_rd [NI];
  logic [7:0] addr   [NI];
  logic       bout   [NI];
  logic       bvalid [NI];
  logic       blast  [NI];
  logic [7:0] bcnt   [NI];
  logic       busy   [NI];
  logic       done   [NI];
  int         rdc    [NI];
  int         rdb    [NI];

  logic [7:0] mem [NI][16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int TBP = TBS[g];
    localparam int WP  = WS[g];
    localparam int NW  = (TBP + WP - 1) / WP;
    localparam int AW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW  = $clog2(TBP + 1);

    logic [AW-1:0] a;
    logic [WP-1:0] rd;
    logic [CW-1:0] c;
    int rc = 0;
    int rb = 0;

    cfg_bitstream_serializer #(
      .TOTAL_BITS (TBP),
      .WORD_W     (WP)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .abort     (abort[g]),
      .mem_rd    (mem_rd[g]),
      .mem_addr  (a),
      .mem_rdata (rd),
      .bit_out   (bout[g]),
      .bit_valid (bvalid[g]),
      .bit_ready (ready[g]),
      .bit_last  (blast[g]),
      .bit_count (c),
      .busy      (busy[g]),
      .done      (done[g])
    );

    assign addr[g] = 8'(a);
    assign bcnt[g] = 8'(c);
    assign rdc[g]  = rc;
    assign rdb[g]  = rb;

    // Synchronous memory; returns garbage on cycles without a read.
    always @(posedge clk) begin
      if (mem_rd[g]) rd <= mem[g][a][WP-1:0];
      else rd <= WP'($urandom);
      if (start[g] && !busy[g] && !done[g]) begin
        rc <= 0;
        rb <= 0;
      end else if (mem_rd[g]) begin
        if (int'(a) != rc) rb <= rb + 1;
        rc <= rc + 1;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input int g);
    logic [63:0] r;
    logic [7:0] w;
    r = '0;
    for (int i = 0; i < TBS[g]; i++) begin
      w = mem[g][i / WS[g]];
      r[i] = w[i % WS[g]];
    end
    return r;
  endfunction

  task automatic run(input int g, input int mode, input int abort_at,
                     input bit start_mid, input logic [63:0] expb,
                     input bit timing);
    int acc, last_cyc, ab_cnt, len, nwd;
    bit fin, aborted, stall, rdy;
    logic pb, pl;
    acc = 0; last_cyc = 0; ab_cnt = 0;
    fin = 0; aborted = 0; stall = 0;
    pb = 0; pl = 0;
    len = TBS[g];
    nwd = (len + WS[g] - 1) / WS[g];
    @(posedge clk); #1;
    start[g] = 1'b1;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      start[g] = 1'b0;
      abort[g] = 1'b0;
      if (start_mid && cyc == 5) start[g] = 1'b1;
      if (aborted) begin
        chk("abort_valid", bvalid[g], 0);
        chk("abort_busy", busy[g], 0);
        chk("abort_rd", mem_rd[g], 0);
        chk("abort_done", done[g], 0);
        ab_cnt++;
        fin = (ab_cnt == 4);
      end else begin
        if (cyc == 1) begin
          chk("fetch_rd", mem_rd[g], 1);
          chk("fetch_addr", addr[g], 0);
          chk("fetch_busy", busy[g], 1);
        end
        if (cyc == 2) begin
          chk("load_rd", mem_rd[g], 0);
          chk("load_valid", bvalid[g], 0);
        end
        if (cyc == 3) begin
          chk("first_valid", bvalid[g], 1);
          chk("prefetch_rd", mem_rd[g], nwd > 1);
        end
        if (timing) begin
          chk("gapless_valid", bvalid[g], cyc >= 3 && cyc < 3 + len);
          chk("done_time", done[g], cyc == 3 + len);
        end
        chk("count", bcnt[g], acc);
        if (bvalid[g]) begin
          chk("busy_valid", busy[g], 1);
          if (stall) begin
            chk("hold_bit", bout[g], pb);
            chk("hold_last", blast[g], pl);
          end
          chk("bit", bout[g], expb[acc]);
          chk("last", blast[g], acc == len - 1);
          case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 3 == 0);
            default: rdy = ($urandom_range(0, 1) == 1);
          endcase
          ready[g] = rdy;
          stall = !rdy;
          pb = bout[g];
          pl = blast[g];
          if (rdy) begin
            acc++;
            last_cyc = cyc;
            if (acc == abort_at) begin
              abort[g] = 1'b1;
              aborted = 1;
            end
          end
        end else begin
          ready[g] = (mode == 0) || ($urandom_range(0, 1) == 1);
          stall = 0;
          if (done[g]) begin
            chk("done_latency", cyc, last_cyc + 1);
            chk("done_busy", busy[g], 0);
            chk("reads", rdc[g], nwd);
            chk("read_order", rdb[g], 0);
            fin = 1;
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: instance %0d got no done within budget", g);
    end
    ready[g] = 1'b0;
    abort[g] = 1'b0;
    start[g] = 1'b0;
    if (fin && !aborted) begin
      @(posedge clk); #1;
      chk("done_pulse", done[g], 0);
      chk("idle_busy", busy[g], 0);
    end
  endtask

  task automatic chk_zero(input int g);
    chk("zero_rd", mem_rd[g], 0);
    chk("zero_addr", addr[g], 0);
    chk("zero_bit", bout[g], 0);
    chk("zero_valid", bvalid[g], 0);
    chk("zero_last", blast[g], 0);
    chk("zero_count", bcnt[g], 0);
    chk("zero_busy", busy[g], 0);
    chk("zero_done", done[g], 0);
  endtask

  typedef struct {
    int          g;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    int          mode;
    int          abort_at;
    bit          start_mid;
    logic [63:0] expb;
    bit          timing;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{0, 8'hC, 8'h3, 8'h0, 0, 0, 1'b0, 64'b111100, 1'b1};
    vt[1] = '{0, 8'hC, 8'h3, 8'h0, 1, 0, 1'b0, 64'b111100, 1'b0};
    vt[2] = '{1, 8'hA, 8'h6, 8'h9, 0, 0, 1'b0, 64'h96A, 1'b1};
    vt[3] = '{0, 8'hC, 8'h3, 8'h0, 0, 3, 1'b0, 64'b111100, 1'b0};
    vt[4] = '{0, 8'hC, 8'h3, 8'h0, 0, 0, 1'b1, 64'b111100, 1'b1};
    vt[5] = '{2, 8'h6, 8'hF, 8'h0, 0, 0, 1'b0, 64'b10110, 1'b1};

    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      abort[g] = 1'b0;
      ready[g] = 1'b0;
      for (int k = 0; k < 16; k++) mem[g][k] = 8'($urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk_zero(g);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      mem[vt[i].g][0] = vt[i].w0;
      mem[vt[i].g][1] = vt[i].w1;
      mem[vt[i].g][2] = vt[i].w2;
      run(vt[i].g, vt[i].mode, vt[i].abort_at, vt[i].start_mid,
          vt[i].expb, vt[i].timing);
      repeat (2) @(posedge clk);
    end

    // Reset dropped mid-stream must clear outputs without a clock edge.
    mem[0][0] = 8'hC;
    mem[0][1] = 8'h3;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_valid", bvalid[0], 1);
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    ready[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int it = 0; it < 24; it++) begin
      int g, mode, ab;
      g = $urandom_range(0, NI - 1);
      for (int k = 0; k < 16; k++) mem[g][k] = 8'($urandom);
      mode = $urandom_range(0, 2);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TBS[g]) : 0;
      run(g, mode, ab, 1'b0, model(g), mode == 0 && ab == 0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
